// File: rtl/reg_sched_pkg.sv
// Shared types and default sizes for the register-bank write scheduler.
// - REG_AW_DEF / DATA_W_DEF / NUM_REGS_DEF: default address width, data width
//   and register count of the bank being driven.
// - state_t: controller state (CLEAR = zero-sweep, RUN = arbitrating).
// - wr_req_t: one write request {addr, data} at the default sizes.
package reg_sched_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter with its pointer flop.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> requester 0)
//   en          : arbitration enable; no grant and no pointer movement when low
//   req0, req1  : request lines
//   gnt0, gnt1  : combinational grants, at most one high, never without request
// Handshake: a grant is the ready of the matching requester; the transfer
// happens on the clock edge where request and grant are both high.
module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr_q = 0 favours requester 0 on contention, 1 favours requester 1.
  logic ptr_q;

  assign gnt0 = en & req0 & (~req1 | ~ptr_q);
  assign gnt1 = en & req1 & (~req0 | ptr_q);

  // Only contended grants move the pointer; a lone requester does not
  // steal the other's next turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (en & req0 & req1) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/reg_write_scheduler.sv
// Owner of the register_bank write port. After reset it zero-sweeps every
// register (the bank has no reset), then shares the port round-robin between
// req0 (core writeback) and req1 (auxiliary/debug loader).
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req0_* / req1_*       : valid/reg/data in, ready out
//   write_reg/write_data/reg_write : registered drive of the bank write port
//   clear_done            : sweep finished (constant 1 when CLEAR_ON_RESET=0)
//   pend_valid/pend_reg   : write being presented now, lands at next edge
//   state                 : current controller state (0 = CLEAR, 1 = RUN)
// Handshake: reqN_ready is combinational from the valids and the arbiter
// pointer, is never high without reqN_valid, and the request is taken on the
// clock edge where valid and ready are both high; the write appears on the
// outputs in the following cycle.
module reg_write_scheduler
  import reg_sched_pkg::*;
#(
  parameter int NUM_REGS       = NUM_REGS_DEF,
  parameter int REG_AW         = REG_AW_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CLEAR_ON_RESET = 1,
  parameter int ZERO_R0        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [REG_AW-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_AW-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              clear_done,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_reg,
  output logic              state
);

  localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d;
  logic              clear_done_d;
  logic [REG_AW-1:0] write_reg_d;
  logic [DATA_W-1:0] write_data_d;
  logic              reg_write_d;
  logic              gnt0, gnt1;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst_n (reset),
    .en    (state_q == RUN),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // A write to r0 is still accepted and shown on write_reg/write_data, but
  // the strobe is withheld so the bank keeps r0 at zero.
  function automatic logic strobe_for(input logic [REG_AW-1:0] r);
    return !((ZERO_R0 != 0) && (r == '0));
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = clear_done;
    write_reg_d  = write_reg;
    write_data_d = write_data;
    reg_write_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        // Sweep write is never suppressed, r0 included.
        reg_write_d  = 1'b1;
        write_reg_d  = cnt_q;
        write_data_d = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_REG) begin
          state_d      = RUN;
          clear_done_d = 1'b1;
        end
      end
      RUN: begin
        if (gnt0) begin
          write_reg_d  = req0_reg;
          write_data_d = req0_data;
          reg_write_d  = strobe_for(req0_reg);
        end else if (gnt1) begin
          write_reg_d  = req1_reg;
          write_data_d = req1_data;
          reg_write_d  = strobe_for(req1_reg);
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q      <= '0;
      clear_done <= (CLEAR_ON_RESET == 0);
      write_reg  <= '0;
      write_data <= '0;
      reg_write  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clear_done <= clear_done_d;
      write_reg  <= write_reg_d;
      write_data <= write_data_d;
      reg_write  <= reg_write_d;
    end
  end

  // The pending write is exactly what the bank port is being driven with.
  assign pend_valid = reg_write;
  assign pend_reg   = write_reg;
  assign state      = state_q;

endmodule

// File: tb/tb_reg_write_scheduler.sv
module tb_reg_write_scheduler;
  import reg_sched_pkg::*;

  localparam int W = REG_AW_DEF + DATA_W_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [4:0]  write_reg, pend_reg;
  logic [31:0] write_data;
  logic        reg_write, clear_done, pend_valid, state;

  // second instance: no sweep after reset
  logic        nc_reset;
  logic        nc_req0_valid, nc_req1_valid;
  logic [4:0]  nc_req0_reg, nc_req1_reg;
  logic [31:0] nc_req0_data, nc_req1_data;
  logic        nc_req0_ready, nc_req1_ready;
  logic [4:0]  nc_write_reg, nc_pend_reg;
  logic [31:0] nc_write_data;
  logic        nc_reg_write, nc_clear_done, nc_pend_valid, nc_state;

  reg_write_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .clear_done(clear_done), .pend_valid(pend_valid), .pend_reg(pend_reg), .state(state)
  );

  reg_write_scheduler #(.CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset(nc_reset),
    .req0_valid(nc_req0_valid), .req0_reg(nc_req0_reg), .req0_data(nc_req0_data), .req0_ready(nc_req0_ready),
    .req1_valid(nc_req1_valid), .req1_reg(nc_req1_reg), .req1_data(nc_req1_data), .req1_ready(nc_req1_ready),
    .write_reg(nc_write_reg), .write_data(nc_write_data), .reg_write(nc_reg_write),
    .clear_done(nc_clear_done), .pend_valid(nc_pend_valid), .pend_reg(nc_pend_reg), .state(nc_state)
  );

  // ---------------- bank model ----------------
  logic [31:0] bank [32];
  logic        bank_fill = 1'b0;
  always @(posedge clk) begin
    if (bank_fill) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'hA5A5_A5A5;
    end else if (reg_write) begin
      bank[write_reg] <= write_data;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: expected bank writes {reg, data} in order
  logic [W-1:0] exp_q[$];
  logic         sb_en = 1'b0;
  always @(negedge clk) begin
    if (sb_en && reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write r%0d=%0h expected none", write_reg, write_data);
      end else begin
        check("sb_write", 64'({write_reg, write_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        v0; logic [4:0] r0; logic [31:0] d0;
    logic        v1; logic [4:0] r1; logic [31:0] d1;
    logic        rdy0; logic rdy1; logic we;
    logic [4:0]  wreg; logic [31:0] wdata;
  } vec_t;
  vec_t vt[15];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
  endtask

  // Called at a negedge right after reset release; checks the full sweep.
  task automatic run_sweep(input string tag);
    drive(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
    for (int i = 0; i < 32; i++) begin
      #1;
      check({tag, "_rdy0"}, 64'(req0_ready), 64'd0);
      check({tag, "_rdy1"}, 64'(req1_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_we"}, 64'(reg_write), 64'd1);
      check({tag, "_reg"}, 64'(write_reg), 64'(i));
      check({tag, "_data"}, 64'(write_data), 64'd0);
      check({tag, "_done"}, 64'(clear_done), 64'(i == 31));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_state_run"}, 64'(state), 64'd1);
    for (int i = 0; i < 32; i++) check({tag, "_bank_zero"}, 64'(bank[i]), 64'd0);
  endtask

  task automatic fill_bank();
    @(negedge clk) bank_fill = 1'b1;
    @(negedge clk) bank_fill = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //        v0 r0  d0             v1 r1  d1             rdy0 rdy1 we  wreg wdata
    vt[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,         1, 0, 1, 5,  32'hDEADBEEF};
    vt[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,         0, 0, 0, 5,  32'hDEADBEEF};
    vt[2]  = '{1, 1,  32'h11,       1, 9,  32'h91,        1, 0, 1, 1,  32'h11};
    vt[3]  = '{1, 2,  32'h22,       1, 9,  32'h91,        0, 1, 1, 9,  32'h91};
    vt[4]  = '{1, 2,  32'h22,       1, 10, 32'hA0,        1, 0, 1, 2,  32'h22};
    vt[5]  = '{1, 3,  32'h33,       1, 10, 32'hA0,        0, 1, 1, 10, 32'hA0};
    vt[6]  = '{0, 0,  32'h0,        1, 0,  32'h1234,      0, 1, 0, 0,  32'h1234};
    vt[7]  = '{0, 0,  32'h0,        1, 7,  32'h77,        0, 1, 1, 7,  32'h77};
    vt[8]  = '{1, 3,  32'h33,       1, 8,  32'h88,        1, 0, 1, 3,  32'h33};
    vt[9]  = '{1, 4,  32'h44,       0, 0,  32'h0,         1, 0, 1, 4,  32'h44};
    vt[10] = '{1, 6,  32'h66,       1, 8,  32'h88,        0, 1, 1, 8,  32'h88};
    vt[11] = '{1, 12, 32'hC0,       1, 12, 32'hC1,        1, 0, 1, 12, 32'hC0};
    vt[12] = '{1, 12, 32'hC0,       1, 12, 32'hC1,        0, 1, 1, 12, 32'hC1};
    vt[13] = '{1, 0,  32'h5555,     0, 0,  32'h0,         1, 0, 0, 0,  32'h5555};
    vt[14] = '{0, 0,  32'h0,        0, 0,  32'h0,         0, 0, 0, 0,  32'h5555};

    reset = 1'b0;
    nc_reset = 1'b0;
    drive(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
    nc_req0_valid = 0; nc_req0_reg = 0; nc_req0_data = 0;
    nc_req1_valid = 0; nc_req1_reg = 0; nc_req1_data = 0;
    fill_bank();

    // reset values
    @(negedge clk);
    check("rst_we", 64'(reg_write), 64'd0);
    check("rst_reg", 64'(write_reg), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    check("rst_done", 64'(clear_done), 64'd0);
    check("rst_pend", 64'(pend_valid), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_rdy0", 64'(req0_ready), 64'd0);
    check("rst_rdy1", 64'(req1_ready), 64'd0);
    check("nc_rst_done", 64'(nc_clear_done), 64'd1);
    check("nc_rst_state", 64'(nc_state), 64'd1);

    // no-sweep instance: usable in the first cycle after release
    nc_reset = 1'b1;
    nc_req0_valid = 1; nc_req0_reg = 5'd3; nc_req0_data = 32'h33;
    #1;
    check("nc_done", 64'(nc_clear_done), 64'd1);
    check("nc_rdy0", 64'(nc_req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("nc_we", 64'(nc_reg_write), 64'd1);
    check("nc_reg", 64'(nc_write_reg), 64'd3);
    check("nc_data", 64'(nc_write_data), 64'h33);
    nc_req0_valid = 0;

    // full sweep from release
    reset = 1'b1;
    run_sweep("sweep");

    // RUN vectors
    sb_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      drive(vt[k].v0, vt[k].r0, vt[k].d0, vt[k].v1, vt[k].r1, vt[k].d1);
      if (vt[k].we) exp_q.push_back({vt[k].wreg, vt[k].wdata});
      #1;
      check($sformatf("v%0d_rdy0", k), 64'(req0_ready), 64'(vt[k].rdy0));
      check($sformatf("v%0d_rdy1", k), 64'(req1_ready), 64'(vt[k].rdy1));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_we", k), 64'(reg_write), 64'(vt[k].we));
      check($sformatf("v%0d_pend", k), 64'(pend_valid), 64'(vt[k].we));
      check($sformatf("v%0d_reg", k), 64'(write_reg), 64'(vt[k].wreg));
      check($sformatf("v%0d_preg", k), 64'(pend_reg), 64'(vt[k].wreg));
      check($sformatf("v%0d_data", k), 64'(write_data), 64'(vt[k].wdata));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 sb_en = 1'b0;
    @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // bank contents after the RUN traffic
    check("bank_r5", 64'(bank[5]), 64'hDEADBEEF);
    check("bank_r1", 64'(bank[1]), 64'h11);
    check("bank_r9", 64'(bank[9]), 64'h91);
    check("bank_r2", 64'(bank[2]), 64'h22);
    check("bank_r10", 64'(bank[10]), 64'hA0);
    check("bank_r0", 64'(bank[0]), 64'h0);
    check("bank_r7", 64'(bank[7]), 64'h77);
    check("bank_r3", 64'(bank[3]), 64'h33);
    check("bank_r4", 64'(bank[4]), 64'h44);
    check("bank_r8", 64'(bank[8]), 64'h88);
    check("bank_r12", 64'(bank[12]), 64'hC1);
    check("bank_r6", 64'(bank[6]), 64'h0);

    // reset asserted in the middle of a sweep
    reset = 1'b0;
    #1;
    check("rrun_we", 64'(reg_write), 64'd0);
    check("rrun_state", 64'(state), 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("mid_reg9", 64'(write_reg), 64'd9);
    reset = 1'b0;
    #1;
    check("abort_we", 64'(reg_write), 64'd0);
    check("abort_reg", 64'(write_reg), 64'd0);
    check("abort_pend", 64'(pend_valid), 64'd0);
    check("abort_done", 64'(clear_done), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    fill_bank();
    @(negedge clk) reset = 1'b1;
    run_sweep("resweep");

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_write_scheduler.md
Name: reg_write_scheduler

Overview:
Controller that owns the single write port of register_bank and shares it between two writeback requesters: req0, the core writeback, and req1, the auxiliary/debug loader. After reset it sweeps every register to zero, because the bank itself has no reset, then arbitrates round-robin between requesters using valid/ready handshakes. Outputs drive register_bank write_reg/write_data/reg_write directly and expose the in-flight write for read bypass.

Parameters:
NUM_REGS, 32, number of registers swept during clear (power of 2, ≤ 2**REG_AW)
REG_AW, 5, register address width
DATA_W, 32, data width
CLEAR_ON_RESET, 1, 1 = run zero-sweep after reset; 0 = enter RUN directly
ZERO_R0, 1, 1 = writes to register 0 accepted but suppressed (reg_write stays 0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req0_valid  in  1  core writeback request
req0_reg  in  REG_AW  destination register
req0_data  in  DATA_W  write data
req0_ready  out  1  req0 accepted this cycle when valid&ready
req1_valid  in  1  auxiliary writeback request
req1_reg  in  REG_AW  destination register
req1_data  in  DATA_W  write data
req1_ready  out  1  req1 accepted this cycle when valid&ready
write_reg  out  REG_AW  to register_bank write_reg
write_data  out  DATA_W  to register_bank write_data
reg_write  out  1  to register_bank reg_write
clear_done  out  1  high once sweep finished, or immediately if CLEAR_ON_RESET=0
pend_valid  out  1  write presented this cycle, landing at next clk edge
pend_reg  out  REG_AW  = write_reg, for read bypass

Behaviour:
- Reset (reset=0, async): write_reg=0, write_data=0, reg_write=0, clear_done=0, pend_valid=0, sweep counter=0, RR pointer=0 (req0 favoured), state=CLEAR (or RUN if CLEAR_ON_RESET=0, which also forces clear_done=1).
- A reset assertion mid-sweep or mid-RUN aborts immediately. On release, the full sweep restarts from register 0.
- State CLEAR:
  - req0_ready=req1_ready=0.
  - Each cycle register reg_write=1, write_reg=cnt, write_data=0; then cnt++.
  - When cnt==NUM_REGS-1 is issued, go to RUN and set clear_done=1 on the same edge.
  - Sweep takes exactly NUM_REGS cycles. The register-0 write during sweep is not suppressed.
- State RUN:
  - readies are combinational from valids and the pointer; there is no backpressure from the bank.
  - Only req0 valid -> req0_ready=1. Only req1 valid -> req1_ready=1.
  - Both valid -> ready to the requester named by the pointer only. The pointer flips to the other requester after every granted both-valid cycle.
  - Single-requester grants leave the pointer unchanged.
  - Neither valid -> readies 0 (ready is never asserted without valid).
- Output register:
  - The accepted request is registered at edge N. write_reg/write_data/reg_write/pend_valid are valid during cycle N→N+1, and the bank commits at edge N+1. Latency is 1 cycle from handshake to outputs, 2 edges to bank contents.
  - A cycle with no grant -> reg_write=0 and pend_valid=0 on the next cycle. write_reg/write_data hold their last values.
- ZERO_R0=1 and granted reg==0: the handshake completes, but reg_write=0 and pend_valid=0. write_reg/write_data still update.
- Two requesters targeting the same register in the same cycle: only one is granted, so writes are serialised in grant order and no merge occurs.
- Throughput is one write per cycle. No internal buffering beyond the single output register.
- States are encoded CLEAR=0, RUN=1. No other states are reachable.

Decomposition:
- Package reg_sched_pkg: REG_AW, DATA_W, NUM_REGS defaults; state enum {CLEAR, RUN}; wr_req struct {reg, data}.
- Sub-module rr_arbiter_2: 2-request round-robin grant plus pointer flop, reusable for other shared ports.
- Top holds the FSM, sweep counter and output register.

Test Plan:
- Release reset with both valids high -> readies 0 for 32 cycles; reg_write=1 with write_reg 0..31 and data 0; clear_done rises after the 32nd write; a bank readback of all registers returns 0.
- RUN, req0 only: reg=5, data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle reg_write=1, write_reg=5, pend_valid=1; register 5 reads 0xDEADBEEF after the following edge.
- Both valid for 4 cycles (req0 reg 1..4, req1 reg 9..12) -> grants alternate req0, req1, req0, req1; writes land at r1, r9, r2, r10.
- ZERO_R0=1, req1 writes reg 0 data 0x1234 -> req1_ready=1, reg_write stays 0, register 0 still reads 0.
- Assert reset at sweep cycle 10, release -> outputs 0 immediately; sweep restarts at write_reg=0 and takes the full 32 cycles.
- CLEAR_ON_RESET=0 -> clear_done=1 right after release; first req0 is accepted in the first cycle.
